// File: rtl/shift_register_univ.sv
// Universal shift register with parallel load, selectable shift/rotate/
// arithmetic modes moving STEP bits per operation, and a burst engine that
// performs a counted run of shifts and reports completion through busy/done.
module shift_register_univ #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int LENW  = $clog2(WIDTH / STEP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dataIn,
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic [STEP-1:0]  serInLsb,
  input  logic [STEP-1:0]  serInMsb,
  input  logic             burstStart,
  input  logic [LENW-1:0]  burstLen,
  output logic [WIDTH-1:0] dataOut,
  output logic [STEP-1:0]  serOutMsb,
  output logic [STEP-1:0]  serOutLsb,
  output logic             busy,
  output logic             done
);

  // A burst never needs more shifts than it takes to flush the whole register.
  localparam int              MAX_SHIFTS = WIDTH / STEP;
  localparam logic [LENW-1:0] MAX_LEN    = LENW'(MAX_SHIFTS);

  // Mode encodings; 110 and 111 are reserved and fall through to hold.
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROTL = 3'b011;
  localparam logic [2:0] MODE_ROTR = 3'b100;
  localparam logic [2:0] MODE_ASR  = 3'b101;

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  reg_q,   reg_d;
  logic [LENW-1:0]   count_q, count_d;
  logic [2:0]        mode_q,  mode_d;
  logic              done_q,  done_d;

  // One shift operation of STEP bits in the given mode.
  function automatic logic [WIDTH-1:0] shift_once(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] r,
    input logic [STEP-1:0]  in_lsb,
    input logic [STEP-1:0]  in_msb
  );
    logic [WIDTH-1:0] res;
    case (m)
      MODE_SHL:  res = {r[WIDTH-STEP-1:0], in_lsb};
      MODE_SHR:  res = {in_msb, r[WIDTH-1:STEP]};
      MODE_ROTL: res = {r[WIDTH-STEP-1:0], r[WIDTH-1 -: STEP]};
      MODE_ROTR: res = {r[STEP-1:0], r[WIDTH-1:STEP]};
      MODE_ASR:  res = {{STEP{r[WIDTH-1]}}, r[WIDTH-1:STEP]};
      default:   res = r;  // MODE_HOLD and reserved encodings
    endcase
    return res;
  endfunction

  // Next-state, next-register and burst bookkeeping for the coming edge.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    reg_d   = reg_q;
    count_d = count_q;
    mode_d  = mode_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          reg_d = dataIn;
        end else if (burstStart) begin
          mode_d  = mode;
          count_d = (burstLen > MAX_LEN) ? MAX_LEN : burstLen;
          // A zero-length burst completes immediately without going busy.
          if (count_d == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = BURST;
          end
        end else if (en) begin
          reg_d = shift_once(mode, reg_q, serInLsb, serInMsb);
        end
      end

      BURST: begin
        if (load) begin
          // Abort: new contents win, and no completion is reported.
          reg_d   = dataIn;
          count_d = '0;
          state_d = IDLE;
        end else begin
          reg_d   = shift_once(mode_q, reg_q, serInLsb, serInMsb);
          count_d = count_q - LENW'(1);
          if (count_q == LENW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register; reset returns everything to idle/zero without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      reg_q   <= '0;
      count_q <= '0;
      mode_q  <= MODE_HOLD;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      reg_q   <= reg_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign dataOut   = reg_q;
  assign serOutMsb = reg_q[WIDTH-1 -: STEP];
  assign serOutLsb = reg_q[STEP-1:0];
  assign busy      = (state_q == BURST);
  assign done      = done_q;

endmodule

// File: doc/shift_register_univ.md
Name: shift_register_univ

Overview:
Parametrised universal shift register, successor to the single-mode serial-in/serial-out shifter. Adds selectable shift/rotate/arithmetic modes and multi-bit steps per cycle. Adds a burst engine that performs a counted run of shifts and reports completion through busy/done. Used in serializer/deserializer front-ends and bit-manipulation datapaths.

Parameters:
WIDTH, 8, register width in bits; must be a multiple of STEP and at least 2*STEP
STEP, 1, bits moved per shift operation; 1 <= STEP < WIDTH
LENW, $clog2(WIDTH/STEP+1), width of burstLen (derived; not to be overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
load  in  1  parallel load of dataIn
dataIn  in  WIDTH  parallel load value
mode  in  3  shift mode (see Behaviour)
en  in  1  single shift this cycle (idle only)
serInLsb  in  STEP  bits entering at LSB end (SHL)
serInMsb  in  STEP  bits entering at MSB end (SHR)
burstStart  in  1  start counted shift burst
burstLen  in  LENW  number of shifts in burst
dataOut  out  WIDTH  register contents
serOutMsb  out  STEP  dataOut[WIDTH-1 -: STEP]
serOutLsb  out  STEP  dataOut[STEP-1:0]
busy  out  1  burst in progress
done  out  1  one-cycle burst-complete pulse

Behaviour:
- Reset (async, immediate, no clock needed): register=0, busy=0, done=0, count=0, latched mode=HOLD. dataOut/serOut* therefore 0.
- dataOut, serOutMsb, serOutLsb are combinational from the register. No extra latency.
- Mode encoding: 000 HOLD; 001 SHL: {reg[WIDTH-STEP-1:0], serInLsb}; 010 SHR: {serInMsb, reg[WIDTH-1:STEP]}; 011 ROTL by STEP; 100 ROTR by STEP; 101 ASR: right by STEP, fill with copies of reg[WIDTH-1]; 110/111 reserved, behave as HOLD.
- States: IDLE, BURST.
- IDLE priority per edge: load > burstStart > en.
  - load: register<=dataIn.
  - burstStart: latch mode; count<=min(burstLen, WIDTH/STEP); register unchanged this edge.
    - If the effective length is 0: stay IDLE, done=1 on the next cycle.
    - Otherwise: go to BURST, busy=1 from the next cycle.
  - en: one shift in the current mode.
- BURST: on each edge, one shift using the latched mode and current serIn* values; count decrements.
  - On the edge where count goes 1->0: go to IDLE, busy<=0, done<=1 for exactly one cycle.
  - busy is high for exactly N cycles for N shifts.
- BURST, load asserted: aborts the burst. register<=dataIn, go to IDLE, busy<=0, no done pulse.
- BURST, en, burstStart and mode changes: ignored.
- done asserted coincident with a new burstStart: the start is accepted normally, since the state is IDLE.
- Reset asserted mid-burst: immediate return to the reset state, no done pulse.

Test Plan:
1. Assert rst between clock edges during a burst -> dataOut=0x00, busy=0, done=0 immediately, before the next edge.
2. WIDTH=8, STEP=1: load 0xA5; mode=SHL, en=1, serInLsb=1 for 1 cycle -> dataOut=0x4B. serOutMsb=1 before the shift, 0 after.
3. Load 0x81; burstStart, mode=ROTR, burstLen=3 -> dataOut 0xC0, 0x60, 0x30 on successive edges. busy high 3 cycles, then done=1 for 1 cycle, then en ignored during busy.
4. Load 0x90; mode=ASR, en for 2 cycles -> 0xC8, 0xE4. Then mode=110, en=1 -> 0xE4 held.
5. Load 0xFF; burst SHL, burstLen=12, serInLsb=0 -> saturates to 8 shifts, dataOut=0x00. busy exactly 8 cycles, one done pulse. Separately, burstLen=0 -> busy stays 0, done pulses once.
6. WIDTH=16, STEP=4: load 0x1234, burst SHR length 2, serInMsb=0xF, with load 0xBEEF asserted on the 2nd busy cycle -> dataOut 0xF123, then 0xBEEF. busy drops, no done pulse.
